// File: rtl/if_stage_pkg.sv
// Shared fetch-pipeline types: reset/bubble defaults, IF/ID bundle and fetch FSM states.
// Pure declarations. No logic, latency or backpressure of its own.
package if_stage_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] inst;
   } if_id_t;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   function automatic if_id_t if_id_bubble(input logic [31:0] nop);
      if_id_t b;
      b.valid = 1'b0;
      b.pc    = 32'h0;
      b.pc4   = 32'h0;
      b.inst  = nop;
      return b;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, imem address and IF/ID bundle out.
// master = fetch stage, slave = surrounding pipeline and instruction memory.
interface if_stage_if;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic [31:0] if_id_inst;
   logic        fetch_misalign;

   modport master (
      input  stall, flush, redirect_valid, redirect_pc, inst,
      output pc, if_id_valid, if_id_pc, if_id_pc4, if_id_inst, fetch_misalign
   );

   modport slave (
      output stall, flush, redirect_valid, redirect_pc, inst,
      input  pc, if_id_valid, if_id_pc, if_id_pc4, if_id_inst, fetch_misalign
   );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register, 1-cycle latency; clear (bubble) beats hold.
// Hold freezes every field so a stalled instruction is neither lost nor duplicated.
module if_stage_if_id_reg
   import if_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_hold,
   input  logic   i_clear,
   input  if_id_t i_dat,
   output if_id_t o_dat
);

   if_id_t r_dat;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_dat <= if_id_bubble(NOP_INST);
      end else if (!i_hold) begin
         r_dat <= i_dat;
      end
   end

   assign o_dat = r_dat;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register + BOOT/RUN FSM feeding IF/ID (pc -> if_id 1 cycle, redirect penalty 1 bubble).
// Stall holds PC and IF/ID; redirect beats stall. FETCH_MISALIGN_CHK_EN flags low-bit redirects.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input logic         clk,
   input logic         rst_n,
   if_stage_if.master  bus
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_nxt;
   logic [31:0]  w_redir_tgt;
   logic         w_hold;
   logic         w_clear;
   if_id_t       w_capture;
   if_id_t       w_if_id;

   // Targets are forced word-aligned; the raw low bits only feed the misalign check.
   assign w_redir_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= BOOT;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_hold      = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         BOOT: begin
            w_state_nxt = RUN;
            w_pc_nxt    = RESET_PC;
            w_clear     = 1'b1;
         end
         RUN: begin
            if (bus.redirect_valid) begin
               w_pc_nxt = w_redir_tgt;
               w_clear  = 1'b1;
            end else begin
               if (!bus.stall) begin
                  w_pc_nxt = r_pc + 32'd4;
               end
               // Flush only kills IF/ID; a concurrent stall still freezes the PC.
               if (bus.flush) begin
                  w_clear = 1'b1;
               end else if (bus.stall) begin
                  w_hold = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = BOOT;
            w_pc_nxt    = RESET_PC;
            w_clear     = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_capture.valid = 1'b1;
      w_capture.pc    = r_pc;
      w_capture.pc4   = r_pc + 32'd4;
      w_capture.inst  = bus.inst;
   end

   if_stage_if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_hold  (w_hold),
      .i_clear (w_clear),
      .i_dat   (w_capture),
      .o_dat   (w_if_id)
   );

`ifdef FETCH_MISALIGN_CHK_EN
   logic r_misalign;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= (r_state == RUN) && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      end
   end

   assign bus.fetch_misalign = r_misalign;
`else
   assign bus.fetch_misalign = 1'b0;
`endif

   assign bus.pc          = r_pc;
   assign bus.if_id_valid = w_if_id.valid;
   assign bus.if_id_pc    = w_if_id.pc;
   assign bus.if_id_pc4   = w_if_id.pc4;
   assign bus.if_id_inst  = w_if_id.inst;

endmodule
